sd_req_arbiter: RTL and testbench
=================================

SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
- REQ-001 SHALL have parameter NUM_REQ, default 3: number of core requesters (2..4).
- REQ-002 SHALL have parameter TIMEOUT_W, default 24: timeout counter width (used only with the timeout feature).
- REQ-003 SHALL have port clk, input, 1: the single clock; all logic is synchronous to it.
- REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port req_rd, input, NUM_REQ: per-requester read request, level, held until that requester's req_done.
- REQ-006 SHALL have port req_wr, input, NUM_REQ: per-requester write request, same rules as req_rd.
- REQ-007 SHALL have port req_sector, input, 32*NUM_REQ: per-requester sector, slice i = [32*i+31:32*i].
- REQ-008 SHALL have port req_slot, input, NUM_REQ: image slot (0/1) that selects the sd_rstart/sd_wstart bit.
- REQ-009 SHALL have port req_inbyte, input, 8*NUM_REQ: per-requester write data for the current sd_outaddr.
- REQ-010 SHALL have port req_busy, output, NUM_REQ: high while requester i is granted.
- REQ-011 SHALL have port req_done, output, NUM_REQ: 1-cycle completion pulse to requester i.
- REQ-012 SHALL have port req_outen, output, NUM_REQ: sd_outen routed to the granted requester only.
- REQ-013 SHALL have port sd_rstart, output, 2: read start to the sd_card core port.
- REQ-014 SHALL have port sd_wstart, output, 2: write start to the sd_card core port.
- REQ-015 SHALL have port sd_sector, output, 32: latched sector of the granted request.
- REQ-016 SHALL have port sd_rdone, input, 1: completion pulse from sd_card.
- REQ-017 SHALL have port sd_outen, input, 1: byte strobe from sd_card; sd_outaddr/sd_outbyte are broadcast to all requesters outside this block.
- REQ-018 SHALL have port sd_inbyte, output, 8: req_inbyte slice of the granted requester, else 8'h00.

Function
- REQ-019 SHALL implement the FSM IDLE -> GRANT -> GAP -> IDLE.
- REQ-020 IDLE: if any req_rd|req_wr is pending, SHALL pick a winner round-robin starting at the index after the last winner (index 0 first after reset), latch its index, sector, slot and op, and enter GRANT on the next edge.
- REQ-021 When one requester asserts both req_rd and req_wr, the read SHALL be served first; the write stays pending.
- REQ-022 GRANT: sd_rstart[slot] or sd_wstart[slot] SHALL be held at 1 and sd_sector held constant; all other start bits SHALL be 0.
- REQ-023 GRANT on sd_rdone SHALL: drop the start bit on the next edge, pulse req_done[g] for exactly one cycle, and enter GAP.
- REQ-024 GAP SHALL last exactly 1 cycle with all start bits 0, so that sd_card sees a fresh rising edge for every grant.
- REQ-025 Request-to-start latency SHALL be 1 cycle; back-to-back grants SHALL be separated by at least 2 cycles.
- REQ-026 An sd_rdone arriving in IDLE or GAP SHALL be ignored.
- REQ-027 Deassertion of the granted request during GRANT SHALL NOT abort the operation; the transfer completes and req_done still pulses.
- REQ-028 req_outen[g] SHALL equal sd_outen during GRANT with an active read, and SHALL be 0 otherwise.

Reset
- REQ-029 On reset SHALL set state=IDLE and the round-robin pointer to index 0, clear all latched requests, and drive every output to 0 on the next edge; an in-flight grant SHALL be dropped without a req_done pulse.

Configuration
- REQ-030 SHALL provide macro SD_ARB_TIMEOUT_EN. When defined, a TIMEOUT_W-bit counter runs in GRANT; at all-ones it forces GAP, pulses req_done[g], and pulses output req_err (1 bit, 1 cycle). When undefined, there is no counter, req_err is tied to 0, and GRANT waits for sd_rdone indefinitely.

Structure
- REQ-031 Package sd_arb_pkg SHALL hold the FSM state encoding, the op enum (RD/WR), and the GAP length constant.
- REQ-032 Round-robin selection SHALL live in the sub-module rr_pick (request vector plus last index in, one-hot winner plus index out).

Verification
- REQ-033 After reset, req_rd=3'b001, slot0, sector 0x0000_0123 -> one cycle later sd_rstart=2'b01, sd_sector=0x123; sd_rdone -> req_done=3'b001 for 1 cycle, sd_rstart=0 for at least 1 cycle.
- REQ-034 req_rd=3'b111 held -> grants in order 0,1,2,0; no two start pulses without a gap cycle.
- REQ-035 Requester 1 with req_rd=req_wr=1, slot1 -> sd_rstart=2'b10 first, then sd_wstart=2'b10; sd_inbyte equals slice 1 only during the write grant.
- REQ-036 Reset asserted mid-GRANT -> all outputs 0 next cycle, no req_done; a later sd_rdone is ignored.
- REQ-037 With SD_ARB_TIMEOUT_EN and TIMEOUT_W=4, no sd_rdone -> after 15 cycles req_err=1 and req_done pulses once; without the macro, sd_rstart is still held after 1000 cycles.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD request arbiter: FSM encoding, operation type
// and the inter-grant gap length.
package sd_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } sd_op_e;

  // Cycles with every start bit low between two grants, so sd_card always
  // sees a fresh rising edge on its start input.
  localparam int GAP_LEN = 1;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Round-robin winner selection: the search starts at the index after last_idx
// and the first pending request wins.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_vld
);

  int cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_idx) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_vld && (|(req & (NUM_REQ'(1) << cand)))) begin
        win_vld = 1'b1;
        win_oh  = NUM_REQ'(1) << cand;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates NUM_REQ read/write requesters onto one sd_card core port.
// Optional grant watchdog enabled with macro SD_ARB_TIMEOUT_EN.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int TIMEOUT_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [32*NUM_REQ-1:0] req_sector,
  input  logic [NUM_REQ-1:0]    req_slot,
  input  logic [8*NUM_REQ-1:0]  req_inbyte,
  output logic [NUM_REQ-1:0]    req_busy,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_outen,
  output logic [1:0]            sd_rstart,
  output logic [1:0]            sd_wstart,
  output logic [31:0]           sd_sector,
  input  logic                  sd_rdone,
  input  logic                  sd_outen,
  output logic [7:0]            sd_inbyte,
  output logic                  req_err
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  logic [1:0]         state;
  logic [IDX_W-1:0]   last_idx;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [31:0]        win_sector;

  logic [NUM_REQ-1:0] gnt_oh_p1;
  logic               gnt_slot_p1;
  sd_op_e             gnt_op_p1;
  logic [31:0]        sector_p1;
  logic [NUM_REQ-1:0] done_p1;
  logic               err_p1;
  logic [1:0]         gap_cnt;
  logic [1:0]         start_vec;
  logic [7:0]         gnt_inbyte;
  logic               in_grant;

`ifdef SD_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
`else
  logic unused_tmo_w;
  assign unused_tmo_w = (TIMEOUT_W != 0);
`endif

  assign pend = req_rd | req_wr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (pend),
    .last_idx (last_idx),
    .win_oh   (win_oh),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  always_comb begin
    win_sector = '0;
    gnt_inbyte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i])    win_sector = req_sector[32*i +: 32];
      if (gnt_oh_p1[i]) gnt_inbyte = req_inbyte[8*i +: 8];
    end
  end

  // Stage p1: grant latch and FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_idx    <= IDX_W'(NUM_REQ - 1);  // next search starts at index 0
      gnt_oh_p1   <= '0;
      gnt_slot_p1 <= 1'b0;
      gnt_op_p1   <= OP_RD;
      sector_p1   <= '0;
      done_p1     <= '0;
      err_p1      <= 1'b0;
      gap_cnt     <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      done_p1 <= '0;
      err_p1  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            gnt_oh_p1   <= win_oh;
            gnt_slot_p1 <= |(req_slot & win_oh);
            gnt_op_p1   <= (|(req_rd & win_oh)) ? OP_RD : OP_WR;
            sector_p1   <= win_sector;
            last_idx    <= win_idx;
            state       <= ST_GRANT;
`ifdef SD_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (sd_rdone) begin
            done_p1 <= gnt_oh_p1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (&tmo_cnt) begin
            done_p1 <= gnt_oh_p1;
            err_p1  <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt == 2'(GAP_LEN - 1)) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_grant  = (state == ST_GRANT);
  assign start_vec = gnt_slot_p1 ? 2'b10 : 2'b01;

  assign sd_rstart = (in_grant && gnt_op_p1 == OP_RD) ? start_vec : 2'b00;
  assign sd_wstart = (in_grant && gnt_op_p1 == OP_WR) ? start_vec : 2'b00;
  assign sd_sector = sector_p1;
  assign sd_inbyte = (in_grant && gnt_op_p1 == OP_WR) ? gnt_inbyte : 8'h00;
  assign req_busy  = in_grant ? gnt_oh_p1 : '0;
  assign req_outen = (in_grant && gnt_op_p1 == OP_RD && sd_outen) ? gnt_oh_p1 : '0;
  assign req_done  = done_p1;

`ifdef SD_ARB_TIMEOUT_EN
  assign req_err = err_p1;
`else
  assign req_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed-vector bench for sd_req_arbiter (3 requesters).
module tb_sd_req_arbiter;

`ifdef SD_ARB_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 24;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  req_rd, req_wr, req_slot;
  logic [95:0] req_sector;
  logic [23:0] req_inbyte;
  logic [2:0]  req_busy, req_done, req_outen;
  logic [1:0]  sd_rstart, sd_wstart;
  logic [31:0] sd_sector;
  logic        sd_rdone, sd_outen;
  logic [7:0]  sd_inbyte;
  logic        req_err;

  int n_vec;
  int n_err;

  sd_req_arbiter #(.NUM_REQ(3), .TIMEOUT_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_sector (req_sector),
    .req_slot   (req_slot),
    .req_inbyte (req_inbyte),
    .req_busy   (req_busy),
    .req_done   (req_done),
    .req_outen  (req_outen),
    .sd_rstart  (sd_rstart),
    .sd_wstart  (sd_wstart),
    .sd_sector  (sd_sector),
    .sd_rdone   (sd_rdone),
    .sd_outen   (sd_outen),
    .sd_inbyte  (sd_inbyte),
    .req_err    (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [2:0] exp_order [4];
  logic [31:0] exp_sec [3];
  int seen_err, seen_done;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    req_rd = '0; req_wr = '0; req_slot = '0;
    req_sector = '0; req_inbyte = '0;
    sd_rdone = 1'b0; sd_outen = 1'b0;
    tick(); tick();
    chk_vec("rst_rstart", 32'(sd_rstart), 32'h0);
    chk_vec("rst_wstart", 32'(sd_wstart), 32'h0);
    chk_vec("rst_busy", 32'(req_busy), 32'h0);
    chk_vec("rst_done", 32'(req_done), 32'h0);
    chk_vec("rst_sector", sd_sector, 32'h0);
    chk_vec("rst_err", 32'(req_err), 32'h0);
    reset = 1'b0;
    tick();

    // single read, requester 0, slot 0
    req_sector = {32'h0000_0789, 32'h0000_0456, 32'h0000_0123};
    req_rd = 3'b001;
    tick();
    chk_vec("t1_rstart", 32'(sd_rstart), 32'h1);
    chk_vec("t1_sector", sd_sector, 32'h123);
    chk_vec("t1_busy", 32'(req_busy), 32'h1);
    chk_vec("t1_inbyte", 32'(sd_inbyte), 32'h0);
    sd_outen = 1'b1; #1;
    chk_vec("t1_outen", 32'(req_outen), 32'h1);
    sd_outen = 1'b0;
    sd_rdone = 1'b1;
    tick();
    chk_vec("t1_done", 32'(req_done), 32'h1);
    chk_vec("t1_gap_rstart", 32'(sd_rstart), 32'h0);
    chk_vec("t1_gap_busy", 32'(req_busy), 32'h0);
    req_rd = 3'b000;
    tick();
    chk_vec("t1_done_once", 32'(req_done), 32'h0);
    tick();
    chk_vec("t1_idle_rdone_ign", 32'(req_done), 32'h0);
    chk_vec("t1_idle_rstart", 32'(sd_rstart), 32'h0);
    sd_rdone = 1'b0;

    // round robin, all three reading
    do_reset();
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    exp_sec[0] = 32'h123; exp_sec[1] = 32'h456; exp_sec[2] = 32'h789;
    req_rd = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_vec($sformatf("rr%0d_busy", n), 32'(req_busy), 32'(exp_order[n]));
      chk_vec($sformatf("rr%0d_sector", n), sd_sector,
              exp_sec[(exp_order[n] == 3'b001) ? 0 : (exp_order[n] == 3'b010) ? 1 : 2]);
      chk_vec($sformatf("rr%0d_rstart", n), 32'(sd_rstart), 32'h1);
      sd_rdone = 1'b1;
      tick();
      sd_rdone = 1'b0;
      chk_vec($sformatf("rr%0d_done", n), 32'(req_done), 32'(exp_order[n]));
      chk_vec($sformatf("rr%0d_gap", n), 32'(sd_rstart), 32'h0);
      req_rd = req_rd & ~exp_order[n];
      tick();
      chk_vec($sformatf("rr%0d_idle", n), 32'(sd_rstart), 32'h0);
      req_rd = req_rd | exp_order[n];
    end
    req_rd = 3'b000;
    tick(); tick();

    // requester 1 read+write on slot 1
    do_reset();
    req_slot = 3'b010;
    req_inbyte = {8'h33, 8'hA5, 8'h11};
    req_rd = 3'b010; req_wr = 3'b010;
    tick();
    chk_vec("rw_rd_rstart", 32'(sd_rstart), 32'h2);
    chk_vec("rw_rd_wstart", 32'(sd_wstart), 32'h0);
    chk_vec("rw_rd_inbyte", 32'(sd_inbyte), 32'h0);
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    chk_vec("rw_rd_done", 32'(req_done), 32'h2);
    req_rd = 3'b000;
    tick();
    chk_vec("rw_idle_wstart", 32'(sd_wstart), 32'h0);
    tick();
    chk_vec("rw_wr_wstart", 32'(sd_wstart), 32'h2);
    chk_vec("rw_wr_rstart", 32'(sd_rstart), 32'h0);
    chk_vec("rw_wr_inbyte", 32'(sd_inbyte), 32'hA5);
    chk_vec("rw_wr_busy", 32'(req_busy), 32'h2);
    sd_outen = 1'b1; #1;
    chk_vec("rw_wr_outen", 32'(req_outen), 32'h0);
    sd_outen = 1'b0;
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    chk_vec("rw_wr_done", 32'(req_done), 32'h2);
    chk_vec("rw_gap_inbyte", 32'(sd_inbyte), 32'h0);
    req_wr = 3'b000; req_slot = 3'b000;
    tick(); tick();

    // reset in the middle of a grant
    do_reset();
    req_rd = 3'b100;
    tick();
    chk_vec("mr_rstart", 32'(sd_rstart), 32'h1);
    chk_vec("mr_sector", sd_sector, 32'h789);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_rd = 3'b000;
    chk_vec("mr_rst_rstart", 32'(sd_rstart), 32'h0);
    chk_vec("mr_rst_busy", 32'(req_busy), 32'h0);
    chk_vec("mr_rst_done", 32'(req_done), 32'h0);
    chk_vec("mr_rst_sector", sd_sector, 32'h0);
    sd_rdone = 1'b1;
    tick();
    chk_vec("mr_late_done0", 32'(req_done), 32'h0);
    tick();
    sd_rdone = 1'b0;
    chk_vec("mr_late_done1", 32'(req_done), 32'h0);
    chk_vec("mr_late_rstart", 32'(sd_rstart), 32'h0);

    // granted request dropped during the grant still completes
    req_rd = 3'b001;
    tick();
    req_rd = 3'b000;
    tick();
    chk_vec("drop_rstart", 32'(sd_rstart), 32'h1);
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    chk_vec("drop_done", 32'(req_done), 32'h1);
    tick(); tick();

    // grant with no sd_rdone
    do_reset();
    req_rd = 3'b001;
    tick();
    req_rd = 3'b000;
`ifdef SD_ARB_TIMEOUT_EN
    seen_err = 0; seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (req_err) seen_err++;
      if (req_done != 3'b000) seen_done++;
    end
    chk_vec("tmo_err_once", 32'(seen_err), 32'd1);
    chk_vec("tmo_done_once", 32'(seen_done), 32'd1);
    chk_vec("tmo_rstart_off", 32'(sd_rstart), 32'h0);
`else
    seen_err = 0; seen_done = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (req_err) seen_err++;
      if (req_done != 3'b000) seen_done++;
    end
    chk_vec("hold_rstart", 32'(sd_rstart), 32'h1);
    chk_vec("hold_no_err", 32'(seen_err), 32'd0);
    chk_vec("hold_no_done", 32'(seen_done), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
